// File: rtl/sym_map_multi.sv
// Octet-to-symbol mapper: BPSK / QPSK / Gray 16-QAM, LSB-first bit consumption.
// Valid/ready on both sides; the next octet is accepted on the last symbol handshake.
module sym_map_multi #(
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned FRAC_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic [7:0]       x_i,
    input  logic             x_valid_i,
    output logic             x_ready_o,
    output logic [OUT_W-1:0] y_i_o,
    output logic [OUT_W-1:0] y_q_o,
    output logic             y_last_o,
    output logic             y_valid_o,
    input  logic             y_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_EMIT = 2'b10
    } state_t;

    localparam int unsigned ONE_I = 1 << FRAC_W;
    localparam int unsigned T_I   = (ONE_I + 1) / 3;

    localparam logic [OUT_W-1:0] P_ONE = OUT_W'(ONE_I);
    localparam logic [OUT_W-1:0] P_T   = OUT_W'(T_I);
    localparam logic [OUT_W-1:0] N_ONE = ~P_ONE + OUT_W'(1);
    localparam logic [OUT_W-1:0] N_T   = ~P_T + OUT_W'(1);

    state_t     state;
    logic [7:0] octet_r;
    logic [1:0] mode_r;
    logic [2:0] idx;

    logic       hs;
    logic       accept;
    logic [7:0] octet_nx;
    logic [2:0] idx_nx;
    logic       last_nx;

    function automatic logic [2:0] bits_per_sym(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd2:    return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [3:0] nsym_of(input logic [1:0] m);
        case (m)
            2'd0:    return 4'd8;
            2'd2:    return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] pm_one(input logic b);
        return b ? P_ONE : N_ONE;
    endfunction

    // Gray order along the axis: 00, 01, 11, 10 from most negative to most positive.
    function automatic logic [OUT_W-1:0] qam_lvl(input logic [1:0] g);
        case (g)
            2'b00:   return N_ONE;
            2'b01:   return N_T;
            2'b11:   return P_T;
            default: return P_ONE;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] map_i(input logic [1:0] m, input logic [3:0] b);
        if (m == 2'd2) return qam_lvl(b[1:0]);
        return pm_one(b[0]);
    endfunction

    function automatic logic [OUT_W-1:0] map_q(input logic [1:0] m, input logic [3:0] b);
        case (m)
            2'd0:    return '0;
            2'd2:    return qam_lvl(b[3:2]);
            default: return pm_one(b[1]);
        endcase
    endfunction

    assign hs        = y_valid_o & y_ready_i;
    assign x_ready_o = rst_n & ((state == S_IDLE) | ((state == S_EMIT) & hs & y_last_o));
    assign accept    = x_valid_i & x_ready_o;

    assign octet_nx = octet_r >> bits_per_sym(mode_r);
    assign idx_nx   = idx + 3'd1;
    assign last_nx  = ({1'b0, idx_nx} == (nsym_of(mode_r) - 4'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            octet_r   <= '0;
            mode_r    <= '0;
            idx       <= '0;
            y_i_o     <= '0;
            y_q_o     <= '0;
            y_last_o  <= 1'b0;
            y_valid_o <= 1'b0;
        end else if (accept) begin
            // Covers both an idle start and a gapless follow-on at the last handshake.
            state     <= S_EMIT;
            octet_r   <= x_i;
            mode_r    <= mode_i;
            idx       <= '0;
            y_i_o     <= map_i(mode_i, x_i[3:0]);
            y_q_o     <= map_q(mode_i, x_i[3:0]);
            y_last_o  <= (nsym_of(mode_i) == 4'd1);
            y_valid_o <= 1'b1;
        end else if ((state == S_EMIT) && hs) begin
            if (y_last_o) begin
                state     <= S_IDLE;
                y_valid_o <= 1'b0;
                y_last_o  <= 1'b0;
            end else begin
                octet_r  <= octet_nx;
                idx      <= idx_nx;
                y_i_o    <= map_i(mode_r, octet_nx[3:0]);
                y_q_o    <= map_q(mode_r, octet_nx[3:0]);
                y_last_o <= last_nx;
            end
        end
    end

endmodule

// File: tb/tb_sym_map_multi.sv
// Directed bench for sym_map_multi: hand-computed symbol sequences per mode,
// backpressure, back-to-back octets, late mode change and mid-octet reset.
module tb_sym_map_multi;

    localparam logic [15:0] P1 = 16'h2000;
    localparam logic [15:0] M1 = 16'hE000;
    localparam logic [15:0] PT = 16'h0AAB;
    localparam logic [15:0] MT = 16'hF555;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [7:0]  x;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] y_i;
    logic [15:0] y_q;
    logic        y_last;
    logic        y_valid;
    logic        y_ready;

    int n_cmp = 0;
    int n_err = 0;

    sym_map_multi #(.OUT_W(16), .FRAC_W(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_i    (mode),
        .x_i       (x),
        .x_valid_i (x_valid),
        .x_ready_o (x_ready),
        .y_i_o     (y_i),
        .y_q_o     (y_q),
        .y_last_o  (y_last),
        .y_valid_o (y_valid),
        .y_ready_i (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_sym(input string tag, input logic [15:0] ei, input logic [15:0] eq,
                           input logic el);
        chk({tag, "_valid"}, {31'd0, y_valid}, 32'd1);
        chk({tag, "_i"}, {16'd0, y_i}, {16'd0, ei});
        chk({tag, "_q"}, {16'd0, y_q}, {16'd0, eq});
        chk({tag, "_last"}, {31'd0, y_last}, {31'd0, el});
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] o);
        mode    = m;
        x       = o;
        x_valid = 1'b1;
        step;
        x_valid = 1'b0;
    endtask

    // Expects symbol 0 of a QPSK 0xB4 octet already on the outputs.
    task automatic qpsk_b4(input string tag);
        chk_sym({tag, "_s0"}, M1, M1, 1'b0);
        chk({tag, "_rdy0"}, {31'd0, x_ready}, 32'd0);
        step;
        chk_sym({tag, "_s1"}, P1, M1, 1'b0);
        chk({tag, "_rdy1"}, {31'd0, x_ready}, 32'd0);
        step;
        chk_sym({tag, "_s2"}, P1, P1, 1'b0);
        chk({tag, "_rdy2"}, {31'd0, x_ready}, 32'd0);
        step;
        chk_sym({tag, "_s3"}, M1, P1, 1'b1);
        chk({tag, "_rdy3"}, {31'd0, x_ready}, 32'd1);
        step;
        chk({tag, "_idle_valid"}, {31'd0, y_valid}, 32'd0);
        chk({tag, "_idle_i_hold"}, {16'd0, y_i}, {16'd0, M1});
        chk({tag, "_idle_q_hold"}, {16'd0, y_q}, {16'd0, P1});
        chk({tag, "_idle_rdy"}, {31'd0, x_ready}, 32'd1);
    endtask

    // Expects symbol 0 of a BPSK 0x01 octet already on the outputs.
    task automatic bpsk_01(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk_sym($sformatf("%s_s%0d", tag, i), (i == 0) ? P1 : M1, 16'h0000, i == 7);
            if (i < 7) step;
        end
        step;
        chk({tag, "_idle_valid"}, {31'd0, y_valid}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        mode    = 2'd0;
        x       = 8'h00;
        x_valid = 1'b0;
        y_ready = 1'b1;

        // Reset state
        step;
        step;
        chk("rst_valid", {31'd0, y_valid}, 32'd0);
        chk("rst_last", {31'd0, y_last}, 32'd0);
        chk("rst_i", {16'd0, y_i}, 32'd0);
        chk("rst_q", {16'd0, y_q}, 32'd0);
        chk("rst_ready", {31'd0, x_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, x_ready}, 32'd1);
        step;

        // QPSK 0xB4
        send(2'd1, 8'hB4);
        qpsk_b4("qpsk");

        // BPSK 0x01
        send(2'd0, 8'h01);
        bpsk_01("bpsk");

        // 16-QAM 0x2D
        send(2'd2, 8'h2D);
        chk_sym("qam_s0", MT, PT, 1'b0);
        step;
        chk_sym("qam_s1", P1, M1, 1'b1);
        step;
        chk("qam_idle_valid", {31'd0, y_valid}, 32'd0);

        // Backpressure on QPSK 0xB4
        send(2'd1, 8'hB4);
        chk_sym("bp_s0", M1, M1, 1'b0);
        step;
        chk_sym("bp_s1", P1, M1, 1'b0);
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            chk_sym($sformatf("bp_hold%0d", i), P1, M1, 1'b0);
            chk($sformatf("bp_hold%0d_rdy", i), {31'd0, x_ready}, 32'd0);
        end
        y_ready = 1'b1;
        step;
        chk_sym("bp_s2", P1, P1, 1'b0);
        step;
        chk_sym("bp_s3", M1, P1, 1'b1);
        step;
        chk("bp_idle_valid", {31'd0, y_valid}, 32'd0);

        // Back-to-back QPSK 0xFF then 0x00
        mode    = 2'd1;
        x       = 8'hFF;
        x_valid = 1'b1;
        step;
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk_sym($sformatf("b2b_a%0d", i), P1, P1, i == 3);
            chk($sformatf("b2b_a%0d_rdy", i), {31'd0, x_ready}, (i == 3) ? 32'd1 : 32'd0);
            step;
        end
        x_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_sym($sformatf("b2b_b%0d", i), M1, M1, i == 3);
            step;
        end
        chk("b2b_idle_valid", {31'd0, y_valid}, 32'd0);

        // Mode change mid-octet only affects the next octet
        send(2'd1, 8'hB4);
        mode = 2'd0;
        qpsk_b4("mchg_q");
        send(2'd0, 8'h01);
        bpsk_01("mchg_b");

        // Mid-octet reset
        send(2'd1, 8'hB4);
        step;
        chk_sym("mrst_pre", P1, M1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, y_valid}, 32'd0);
        chk("mrst_i", {16'd0, y_i}, 32'd0);
        chk("mrst_q", {16'd0, y_q}, 32'd0);
        chk("mrst_ready", {31'd0, x_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_post_ready", {31'd0, x_ready}, 32'd1);
        step;
        send(2'd1, 8'hB4);
        qpsk_b4("mrst_q");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
